simon_keyexpansion: RTL and testbench

//  Computes the next SIMON round key from the current M-word key window.

---
 rtl/simon_keyexpansion.sv | 84 ++++++++
 tb/tb_simon_keyexpansion.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/simon_keyexpansion.sv
// SIMON key-schedule step: produces k[i+M] from the current M-word key window,
// registered with one cycle of latency.
module simon_keyexpansion #(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int J  = 0,
  parameter int CW = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CW-1:0]       count,
  input  logic [M-1:0][N-1:0] keys,
  output logic [N-1:0]        out,
  output logic                out_valid
);

  generate
    if (!(N == 16 || N == 24 || N == 32 || N == 48 || N == 64)) begin : g_bad_n
      $error("simon_keyexpansion: N must be 16, 24, 32, 48 or 64");
    end
    if (M < 2 || M > 4) begin : g_bad_m
      $error("simon_keyexpansion: M must be 2, 3 or 4");
    end
    if (J < 0 || J > 4) begin : g_bad_j
      $error("simon_keyexpansion: J must be 0..4");
    end
    if (CW < 6) begin : g_bad_cw
      $error("simon_keyexpansion: CW must be at least 6");
    end
  endgenerate

  // Ascending range so that bit 0 is the first bit of the published sequence.
  function automatic logic [0:61] zseq(input int j);
    case (j)
      0:       return 62'b11111010001001010110000111001101111101000100101011000011100110;
      1:       return 62'b10001110111110010011000010110101000111011111001001100001011010;
      2:       return 62'b10101111011100000011010010011000101000010001111110010110110011;
      3:       return 62'b11011011101011000110010111100000010010001010011100110100001111;
      default: return 62'b11010001111001101011011000100000010111000011001010010011101111;
    endcase
  endfunction

  localparam logic [0:61]  ZSEL = zseq(J);
  localparam logic [N-1:0] C    = {{(N-2){1'b1}}, 2'b00};

  function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int s);
    return (x >> s) | (x << (N - s));
  endfunction

  function automatic logic [N-1:0] round_key(input logic [M-1:0][N-1:0] k,
                                             input logic z);
    logic [N-1:0] t;
    t = ror(k[M-1], 3);
    if (M == 4) t = t ^ k[1];
    t = t ^ ror(t, 1);
    return k[0] ^ t ^ C ^ {{(N-1){1'b0}}, z};
  endfunction

  logic [5:0]   w_zidx;
  logic         w_zbit;
  logic [N-1:0] w_next;
  logic [N-1:0] r_out_p0;
  logic         r_vld_p0;

  assign w_zidx = 6'(count % CW'(62));
  assign w_zbit = ZSEL[w_zidx];
  assign w_next = round_key(keys, w_zbit);

  // Stage p0: registered round key and its valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_out_p0 <= '0;
    end else begin
      r_vld_p0 <= in_valid;
      if (in_valid) r_out_p0 <= w_next;
    end
  end

  assign out       = r_out_p0;
  assign out_valid = r_vld_p0;

endmodule

// File: tb/tb_simon_keyexpansion.sv
// Scoreboarded bench for simon_keyexpansion: an N=16/M=4/J=0 instance with directed
// and random rounds, plus an N=24/M=3/J=1 instance against a string-based golden model.
module tb_simon_keyexpansion;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic            va;
  logic [31:0]     ca;
  logic [3:0][15:0] ka;
  logic [15:0]     oa;
  logic            ova;

  logic            vb;
  logic [31:0]     cb;
  logic [2:0][23:0] kb;
  logic [23:0]     ob;
  logic            ovb;

  int checks = 0;
  int errors = 0;

  logic [15:0] qa[$];
  logic [23:0] qb[$];

  simon_keyexpansion #(.N(16), .M(4), .J(0), .CW(32)) dut_a (
    .clk(clk), .rst(rst), .in_valid(va), .count(ca), .keys(ka),
    .out(oa), .out_valid(ova)
  );

  simon_keyexpansion #(.N(24), .M(3), .J(1), .CW(32)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .count(cb), .keys(kb),
    .out(ob), .out_valid(ovb)
  );

  // Golden model: z sequences held as text, rotations on 64-bit integers.
  function automatic bit zbit(input int j, input longint unsigned cnt);
    string s;
    int idx;
    idx = int'(cnt % 62);
    case (j)
      0: s = "11111010001001010110000111001101111101000100101011000011100110";
      1: s = "10001110111110010011000010110101000111011111001001100001011010";
      2: s = "10101111011100000011010010011000101000010001111110010110110011";
      3: s = "11011011101011000110010111100000010010001010011100110100001111";
      default: s = "11010001111001101011011000100000010111000011001010010011101111";
    endcase
    return s[idx] == 8'h31;
  endfunction

  function automatic longint unsigned rotr(input longint unsigned x, input int s, input int n);
    longint unsigned mask;
    mask = (64'd1 << n) - 64'd1;
    return ((x >> s) | (x << (n - s))) & mask;
  endfunction

  function automatic longint unsigned model(input int n, input int m, input int j,
                                            input longint unsigned k[4],
                                            input longint unsigned cnt);
    longint unsigned mask, t, res;
    mask = (64'd1 << n) - 64'd1;
    t = rotr(k[m-1], 3, n);
    if (m == 4) t = t ^ k[1];
    t = t ^ rotr(t, 1, n);
    res = k[0] ^ t ^ (mask - 64'd3) ^ longint'(zbit(j, cnt));
    return res & mask;
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [31:0] c,
                         input logic [15:0] k0, input logic [15:0] k1,
                         input logic [15:0] k2, input logic [15:0] k3,
                         input logic [15:0] exp, input bit use_exp);
    longint unsigned kk[4];
    va = v;
    ca = c;
    ka = {k3, k2, k1, k0};
    kk = '{longint'(k0), longint'(k1), longint'(k2), longint'(k3)};
    if (v && !rst) begin
      if (use_exp) qa.push_back(exp);
      else         qa.push_back(16'(model(16, 4, 0, kk, longint'(c))));
    end
  endtask

  task automatic drive_b(input logic v, input logic [31:0] c,
                         input logic [23:0] k0, input logic [23:0] k1,
                         input logic [23:0] k2);
    longint unsigned kk[4];
    vb = v;
    cb = c;
    kb = {k2, k1, k0};
    kk = '{longint'(k0), longint'(k1), longint'(k2), 64'd0};
    if (v && !rst) qb.push_back(24'(model(24, 3, 1, kk, longint'(c))));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare whenever a DUT presents a result.
  always @(negedge clk) begin
    if (ova === 1'b1) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL A unexpected out_valid: got out=%0h, expected no result", oa);
      end else begin
        check("A out", longint'(oa), longint'(qa.pop_front()));
      end
    end
    if (ovb === 1'b1) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL B unexpected out_valid: got out=%0h, expected no result", ob);
      end else begin
        check("B out", longint'(ob), longint'(qb.pop_front()));
      end
    end
  end

  initial begin
    logic [31:0] c;
    rst = 1'b1;
    drive_a(1'b1, 32'd0, 16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h0, 1'b0);
    drive_b(1'b1, 32'd3, 24'h123456, 24'h789abc, 24'hdef012);

    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset A out", longint'(oa), 64'd0);
      check("reset A out_valid", longint'(ova), 64'd0);
      check("reset B out", longint'(ob), 64'd0);
      check("reset B out_valid", longint'(ovb), 64'd0);
    end

    rst = 1'b0;
    drive_b(1'b0, 32'd0, 24'h0, 24'h0, 24'h0);
    drive_a(1'b1, 32'd0,   16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C3, 1'b1); tick();
    drive_a(1'b1, 32'd1,   16'h0908, 16'h1110, 16'h1918, 16'h71C3, 16'hB649, 1'b1); tick();
    drive_a(1'b1, 32'd2,   16'h1110, 16'h1918, 16'h71C3, 16'hB649, 16'h56D4, 1'b1); tick();
    drive_a(1'b1, 32'd62,  16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C3, 1'b1); tick();
    drive_a(1'b1, 32'd5,   16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C2, 1'b1); tick();
    drive_a(1'b1, 32'd124, 16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C3, 1'b1); tick();

    drive_a(1'b0, 32'd7, 16'hAAAA, 16'h5555, 16'h1234, 16'h4321, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold A out", longint'(oa), 64'h71C3);
      check("hold A out_valid", longint'(ova), 64'd0);
    end

    for (int i = 0; i < 200; i++) begin
      c = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 200)) : $urandom();
      drive_a(($urandom_range(0, 4) != 0), c,
              16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()),
              16'h0, 1'b0);
      c = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 200)) : $urandom();
      drive_b(($urandom_range(0, 4) != 0), c,
              24'($urandom()), 24'($urandom()), 24'($urandom()));
      tick();
    end

    drive_a(1'b1, 32'd9, 16'hBEEF, 16'hCAFE, 16'h0F0F, 16'hF00D, 16'h0, 1'b0);
    drive_b(1'b1, 32'd70, 24'hABCDEF, 24'h13579B, 24'h2468AC);
    tick();
    rst = 1'b1;
    drive_a(1'b1, 32'd10, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 1'b0);
    drive_b(1'b1, 32'd11, 24'h111111, 24'h222222, 24'h333333);
    tick();
    check("midreset A out", longint'(oa), 64'd0);
    check("midreset A out_valid", longint'(ova), 64'd0);
    check("midreset B out", longint'(ob), 64'd0);
    check("midreset B out_valid", longint'(ovb), 64'd0);
    rst = 1'b0;
    drive_a(1'b0, 32'd0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    drive_b(1'b0, 32'd0, 24'h0, 24'h0, 24'h0);

    for (int i = 0; i < 4; i++) tick();
    check("A scoreboard drained", longint'(qa.size()), 64'd0);
    check("B scoreboard drained", longint'(qb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
